aes_128_inv: RTL and testbench
==============================

// Module: aes_128_inv
// PURPOSE
// - Fine-grained multicycle AES-128 inverse cipher (FIPS-197 sec 5.3); receive-side counterpart of the fine multicycle encryptor.
// - Takes ciphertext plus the ORIGINAL cipher key. Expands the key forward to round key 10, then runs inverse rounds one sub-step per cycle.
// - Rolls the key back with an inverse key schedule, so no round-key storage is needed.
// PARAMETERS
// - OUT_REG  0  0: out_bus combinational from state/key_reg; 1: out_bus registered, +1 cycle latency
// PORTS
// - clk      in   1    single clock, all flops on posedge
// - rst_n    in   1    asynchronous active-low reset
// - in_bus   in   128  ciphertext, sampled on the posedge where ready=1
// - key      in   128  cipher key (round key 0), sampled with in_bus
// - out_bus  out  128  plaintext, meaningful only while valid=1
// - ready    out  1    if 1 on a posedge, in_bus/key are sampled
// - valid    out  1    out_bus = decryption of the last sampled in_bus under the last sampled key
// BEHAVIOUR
// - Regs: state[127:0], key_reg[127:0], FSM, rnd[3:0], step[1:0]. Word w0 = bits[127:96]; column-major byte order as the encryptor.
// - Reset (async): all regs 0, FSM=IDLE, ready=1, valid=0.
//   - out_bus = 128'h5252..52 (InvSubBytes(0)^0) if OUT_REG=0; 0 if OUT_REG=1.
//   - Reset mid-operation aborts; no output is produced.
// - FSM (ready=1 only in IDLE and DONE):
//   - IDLE: on the ready edge, state<=in_bus, key_reg<=key, rnd<=0 -> KEXP.
//   - KEXP: 10 cycles; key_reg<=KS(key_reg, rcon[rnd]), rnd++. After rnd=9, key_reg=k10 -> ADD0.
//   - ADD0: state<=state^key_reg; key_reg<=IKS(key_reg, rcon[9]) (now k9); rnd<=9, step<=0 -> RND.
//   - RND (r=rnd, 9..1):
//     - step0: state<=InvShiftRows(state).
//     - step1: state<=InvSubBytes(state)^key_reg; key_reg<=IKS(key_reg, rcon[r-1]).
//     - step2: state<=InvMixColumns(state); rnd--. Leaves to FIN when rnd was 1.
//   - FIN: state<=InvShiftRows(state) -> DONE. key_reg now holds k0.
//   - DONE: valid=1, ready=1 for exactly one cycle. out_bus=InvSubBytes(state)^key_reg. A sample on this edge starts the next block (-> KEXP), else -> IDLE.
// - Key schedule:
//   - rcon[i] = {01,02,04,08,10,20,40,80,1b,36}[i] in byte 3 of the word; indices >9 give 0.
//   - Forward KS: w0^=SubWord(RotWord(w3))^rcon, then w1^=w0, w2^=w1, w3^=w2.
//   - IKS: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^rcon.
// - Latency, OUT_REG=0: valid in the 39th cycle after the sampling edge (10 KEXP+1 ADD0+27 RND+1 FIN). Throughput 1 block / 40 cycles.
// - OUT_REG=1: DONE loads out_q; valid/ready move to a following DONE2 cycle (latency 40, 1 block / 41 cycles).
// - in_bus/key changes while ready=0 are ignored. valid never asserts without a prior sample. No backpressure: the consumer must take out_bus in the valid cycle.
// CONFIGURATION
// - AES_INV_KEY_CACHE_EN defined:
//   - Adds regs last_key and last_k10 plus a cache_ok bit. cache_ok is 0 at reset, set at each KEXP completion, never cleared by data.
//   - On the sample edge, if cache_ok and key==last_key: key_reg<=last_k10 and go straight to ADD0. Latency 29 (OUT_REG=0); miss path unchanged.
//   - KEXP completion writes last_key / last_k10.
// - Not defined: no cache regs; every block runs KEXP.
// TESTING
// - FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, in_bus 69c4e0d86a7b0430d8cdb78070b4c55a -> out_bus 00112233445566778899aabbccddeeff.
//   - valid exactly 39 cycles after sample; ready=0 in between.
// - FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, in 3925841d02dc09fbdc118597196a0b32 -> out 3243f6a8885a308d313198a2e0370734.
//   - key_reg=d014f9a8c9ee2589e13f0cc8b6630ca6 at KEXP exit.
// - Back-to-back: hold ready-qualified inputs C.1 then B. Second sample occurs on the first DONE edge; both results correct; valid pulses 40 cycles apart.
// - Input churn: toggle in_bus/key randomly every cycle while ready=0 -> result unaffected.
// - Reset mid-round: assert rst_n=0 at cycle 20 -> immediately ready=1, valid=0, out_bus=5252..52.
//   - After release, C.1 decrypts correctly.
// - AES_INV_KEY_CACHE_EN: C.1 twice with the same key -> second valid after 29 cycles. Then B key -> 39 cycles.
//   - Reset then C.1 -> 39 cycles (cache invalidated).

Source files
------------

// File: rtl/aes_128_inv.sv
// aes_128_inv: multicycle AES-128 inverse cipher, one sub-step per cycle.
// The key is expanded forward to round key 10, then rolled back one round
// at a time with the inverse key schedule, so no round-key storage exists.
// OUT_REG=0 drives out_bus combinationally; OUT_REG=1 adds an output register
// and an extra DONE2 cycle.
// Optional feature macro: AES_INV_KEY_CACHE_EN (remembers the last expanded
// key so that a repeated key skips the forward expansion).
`timescale 1ns/1ps

module aes_128_inv #(
    parameter int OUT_REG = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] in_bus,
    input  logic [127:0] key,
    output logic [127:0] out_bus,
    output logic         ready,
    output logic         valid
);

    localparam bit LP_REG = (OUT_REG != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEXP  = 3'd1,
        S_ADD0  = 3'd2,
        S_RND   = 3'd3,
        S_FIN   = 3'd4,
        S_DONE  = 3'd5,
        S_DONE2 = 3'd6
    } state_t;

    // ---------------- GF(2^8) and AES primitives ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0 as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // SubWord(RotWord(w))
    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] ks_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] ks_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0]  ^ k[63:32];
        n2 = k[63:32] ^ k[95:64];
        n1 = k[95:64] ^ k[127:96];
        n0 = k[127:96] ^ sub_rot(n3) ^ {rc, 24'h0};
        return {n0, n1, n2, n3};
    endfunction

    // Row r rotates right by r columns; byte n sits at row n%4, column n/4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // ---------------- registers and shared datapath ----------------
    state_t       r_fsm, w_fsm_next;
    logic [127:0] r_state, w_state_next;
    logic [127:0] r_key, w_key_next;
    logic [3:0]   r_rnd, w_rnd_next;
    logic [1:0]   r_step, w_step_next;
    logic [127:0] r_out;
    logic         w_load_out;
    logic         w_sample;

    logic [127:0] w_isb;       // InvSubBytes(state), shared by round step 1 and the output
    logic [127:0] w_plain;     // InvSubBytes(state) ^ key_reg
    logic [127:0] w_ks;        // forward schedule step with rcon[rnd]
    logic [127:0] w_iks;       // inverse schedule step (rcon[9] in ADD0, rcon[rnd-1] in rounds)
    logic [3:0]   w_iks_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_isb
            assign w_isb[127 - 8*gi -: 8] = inv_sbox(r_state[127 - 8*gi -: 8]);
        end
    endgenerate

    assign w_plain   = w_isb ^ r_key;
    assign w_ks      = ks_fwd(r_key, rcon(r_rnd));
    assign w_iks_idx = (r_fsm == S_ADD0) ? 4'd9 : (r_rnd - 4'd1);
    assign w_iks     = ks_inv(r_key, rcon(w_iks_idx));
    assign out_bus   = LP_REG ? r_out : w_plain;

`ifdef AES_INV_KEY_CACHE_EN
    logic [127:0] r_last_key;
    logic [127:0] r_last_k10;
    logic         r_cache_ok;
    logic         w_hit;

    assign w_hit = r_cache_ok && (key == r_last_key);

    // Cache of the most recently expanded key. The original key is captured
    // on the miss sample because key_reg is overwritten during expansion; no
    // other sample can happen before that expansion completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_key <= '0;
            r_last_k10 <= '0;
            r_cache_ok <= 1'b0;
        end else begin
            if (w_sample && !w_hit) r_last_key <= key;
            if (r_fsm == S_KEXP && r_rnd == 4'd9) begin
                r_last_k10 <= w_ks;
                r_cache_ok <= 1'b1;
            end
        end
    end
`endif

    // State, key, counters and FSM register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_key   <= '0;
            r_rnd   <= '0;
            r_step  <= '0;
        end else begin
            r_fsm   <= w_fsm_next;
            r_state <= w_state_next;
            r_key   <= w_key_next;
            r_rnd   <= w_rnd_next;
            r_step  <= w_step_next;
        end
    end

    // Registered output copy, loaded in DONE (only used when OUT_REG=1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (w_load_out) begin
            r_out <= w_plain;
        end
    end

    // Next-state, datapath selection and handshake outputs. With no input
    // strobe, every ready edge samples, so the core free-runs block after block.
    always_comb begin
        w_fsm_next   = r_fsm;
        w_state_next = r_state;
        w_key_next   = r_key;
        w_rnd_next   = r_rnd;
        w_step_next  = r_step;
        w_load_out   = 1'b0;
        valid        = 1'b0;
        w_sample     = 1'b0;

        if (r_fsm == S_IDLE) begin
            w_sample = 1'b1;
        end else if ((r_fsm == S_DONE && !LP_REG) || r_fsm == S_DONE2) begin
            w_sample = 1'b1;
            valid    = 1'b1;
        end
        ready = w_sample;

        if (w_sample) begin
            w_state_next = in_bus;
            w_key_next   = key;
            w_rnd_next   = 4'd0;
            w_step_next  = 2'd0;
            w_fsm_next   = S_KEXP;
`ifdef AES_INV_KEY_CACHE_EN
            if (w_hit) begin
                w_key_next = r_last_k10;
                w_fsm_next = S_ADD0;
            end
`endif
        end else begin
            case (r_fsm)
                S_KEXP: begin
                    w_key_next = w_ks;
                    w_rnd_next = r_rnd + 4'd1;
                    if (r_rnd == 4'd9) w_fsm_next = S_ADD0;
                end
                S_ADD0: begin
                    w_state_next = r_state ^ r_key;
                    w_key_next   = w_iks;
                    w_rnd_next   = 4'd9;
                    w_step_next  = 2'd0;
                    w_fsm_next   = S_RND;
                end
                S_RND: begin
                    case (r_step)
                        2'd0: begin
                            w_state_next = inv_shift_rows(r_state);
                            w_step_next  = 2'd1;
                        end
                        2'd1: begin
                            w_state_next = w_plain;
                            w_key_next   = w_iks;
                            w_step_next  = 2'd2;
                        end
                        default: begin
                            w_state_next = inv_mix_columns(r_state);
                            w_rnd_next   = r_rnd - 4'd1;
                            w_step_next  = 2'd0;
                            if (r_rnd == 4'd1) w_fsm_next = S_FIN;
                        end
                    endcase
                end
                S_FIN: begin
                    w_state_next = inv_shift_rows(r_state);
                    w_fsm_next   = S_DONE;
                end
                S_DONE: begin
                    // Reached only with the output register enabled.
                    w_load_out = 1'b1;
                    w_fsm_next = S_DONE2;
                end
                default: begin
                    w_fsm_next = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_128_inv.sv
// tb_aes_128_inv: randomized scoreboard bench for aes_128_inv.
// A driver presents planned or random blocks whenever ready is high and
// churns the inputs otherwise; a sampler pushes the expected plaintext and
// latency per sample; a monitor pops and compares on every valid pulse.
`timescale 1ns/1ps

module tb_aes_128_inv;

    localparam int OUT_REG  = 0;
    localparam int BASE_LAT = 39 + OUT_REG;
    localparam int HIT_LAT  = 29 + OUT_REG;
    localparam logic [127:0] RESET_OUT = (OUT_REG != 0) ? 128'h0 : {16{8'h52}};

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_bus;
    logic [127:0] key;
    logic [127:0] out_bus;
    logic         ready;
    logic         valid;

    aes_128_inv #(.OUT_REG(OUT_REG)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_bus  (in_bus),
        .key     (key),
        .out_bus (out_bus),
        .ready   (ready),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] key;
    } vec_t;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] key;
        logic [127:0] pt;
        longint       sc;
        int           lat;
    } exp_t;

    vec_t   plan_q[$];
    exp_t   sb_q[$];
    int     errors   = 0;
    int     checks   = 0;
    int     done_cnt = 0;
    longint cyc      = 0;

    logic [7:0] sbox_t [256];
    logic [7:0] inv_t  [256];

`ifdef AES_INV_KEY_CACHE_EN
    logic         m_cache_ok = 1'b0;
    logic [127:0] m_last_key = '0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // S-box built by walking the multiplicative group with generator 3.
    initial begin : build_tables
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = 8'(i);
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mulc(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] a2, a4, a8;
        a2 = xt(a);
        a4 = xt(a2);
        a8 = xt(a4);
        return (c[0] ? a : 8'h00) ^ (c[1] ? a2 : 8'h00) ^ (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
    endfunction

    // Textbook inverse cipher: full 44-word expansion, then 4x4 byte matrix.
    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   m [4][4];
        logic [7:0]   t [4][4];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = ct[127 - 8*(4*c + r) -: 8] ^ w[40 + c][31 - 8*r -: 8];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][(c + r) % 4] = m[r][c];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    m[r][c] = inv_t[t[r][c]] ^ w[4*rd + c][31 - 8*r -: 8];
            if (rd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = m[0][c]; a1 = m[1][c]; a2 = m[2][c]; a3 = m[3][c];
                    m[0][c] = mulc(a0, 4'he) ^ mulc(a1, 4'hb) ^ mulc(a2, 4'hd) ^ mulc(a3, 4'h9);
                    m[1][c] = mulc(a0, 4'h9) ^ mulc(a1, 4'he) ^ mulc(a2, 4'hb) ^ mulc(a3, 4'hd);
                    m[2][c] = mulc(a0, 4'hd) ^ mulc(a1, 4'h9) ^ mulc(a2, 4'he) ^ mulc(a3, 4'hb);
                    m[3][c] = mulc(a0, 4'hb) ^ mulc(a1, 4'hd) ^ mulc(a2, 4'h9) ^ mulc(a3, 4'he);
                end
            end
        end
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(4*c + r) -: 8] = m[r][c];
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present the next planned block while ready, otherwise random churn.
    task automatic drive_next();
        vec_t v;
        if (ready === 1'b1 && plan_q.size() > 0) begin
            v      = plan_q.pop_front();
            in_bus = v.ct;
            key    = v.key;
        end else begin
            in_bus = rand128();
            key    = rand128();
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            drive_next();
            n++;
        end
        if (done_cnt < target) chk("timeout_done_count", 128'(done_cnt), 128'(target));
    endtask

    // Sampler: records what the next edge will capture and what must come out.
    always @(negedge clk) begin : sampler
        exp_t e;
        if (rst_n !== 1'b1) begin
`ifdef AES_INV_KEY_CACHE_EN
            m_cache_ok = 1'b0;
`endif
        end else if (ready === 1'b1) begin
            e.ct  = in_bus;
            e.key = key;
            e.sc  = cyc + 1;
            if (in_bus == C1_CT && key == C1_KEY)     e.pt = C1_PT;
            else if (in_bus == B_CT && key == B_KEY)  e.pt = B_PT;
            else                                      e.pt = ref_decrypt(in_bus, key);
            e.lat = BASE_LAT;
`ifdef AES_INV_KEY_CACHE_EN
            if (m_cache_ok && key == m_last_key) begin
                e.lat = HIT_LAT;
            end else begin
                m_last_key = key;
                m_cache_ok = 1'b1;
            end
`endif
            sb_q.push_back(e);
        end
    end

    // Monitor: one comparison set per valid pulse, busy checks in between.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n !== 1'b1) begin
            sb_q.delete();
        end else if (valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("valid_without_sample", 128'(valid), 128'd0);
            end else begin
                e = sb_q.pop_front();
                chk("plaintext", out_bus, e.pt);
                chk("latency", 128'(cyc - e.sc), 128'(e.lat));
                chk("ready_in_done", 128'(ready), 128'd1);
                $display("txn %0d ct=%h key=%h pt=%h lat=%0d", done_cnt, e.ct, e.key, out_bus, cyc - e.sc);
                done_cnt++;
            end
        end else if (sb_q.size() > 0 && sb_q[0].sc <= cyc) begin
            chk("ready_while_busy", 128'(ready), 128'd0);
        end
    end

    initial begin : main
        vec_t   v;
        logic [127:0] rk;
        rst_n  = 1'b0;
        in_bus = C1_CT;
        key    = C1_KEY;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 128'(ready), 128'd1);
        chk("reset_valid", 128'(valid), 128'd0);
        chk("reset_out_bus", out_bus, RESET_OUT);

        // C.1 twice (same key), then B back-to-back, then random blocks.
        v.ct = C1_CT; v.key = C1_KEY; plan_q.push_back(v);
        v.ct = C1_CT; v.key = C1_KEY; plan_q.push_back(v);
        v.ct = B_CT;  v.key = B_KEY;  plan_q.push_back(v);
        rk = rand128();
        v.ct = rand128(); v.key = rk; plan_q.push_back(v);
        v.ct = rand128(); v.key = rk; plan_q.push_back(v);
        for (int i = 0; i < 3; i++) begin
            v.ct = rand128(); v.key = rand128(); plan_q.push_back(v);
        end

        rst_n = 1'b1;
        drive_next();
        wait_done(8, 8 * 45);

        // Reset roughly 20 cycles into the next (random) block.
        repeat (19) begin
            @(posedge clk);
            #1;
            drive_next();
        end
        rst_n = 1'b0;
        #1;
        chk("midreset_ready", 128'(ready), 128'd1);
        chk("midreset_valid", 128'(valid), 128'd0);
        chk("midreset_out_bus", out_bus, RESET_OUT);
        repeat (2) @(posedge clk);
        #1;
        plan_q.delete();
        v.ct = C1_CT; v.key = C1_KEY; plan_q.push_back(v);
        v.ct = C1_CT; v.key = C1_KEY; plan_q.push_back(v);
        v.ct = B_CT;  v.key = B_KEY;  plan_q.push_back(v);
        rst_n = 1'b1;
        drive_next();
        wait_done(11, 3 * 45);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
